// File: rtl/fifo_wr_sched.sv
// fifo_wr_sched -- packet-level round-robin write scheduler for the shared FIFO.
//
// NREQ requester streams compete for the single FIFO write port. A requester
// keeps the grant for a whole packet, so packets never interleave. A packet is
// admitted only while the FIFO has room for a maximum-size packet.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid     per-requester beat valid
//   req_data      per-requester beat, requester i at [i*WIDTH +: WIDTH]
//   req_last      per-requester final-beat marker
//   req_ready     per-requester beat accept
//   fifo_wr_en    FIFO write enable (combinational, same cycle as accept)
//   fifo_wr_data  FIFO write data (granted requester's beat)
//   fifo_full     FIFO full flag
//   fifo_used     FIFO occupancy
//   grant_id      currently / last granted requester
//   busy          high while a packet is locked (FSM state LOCK)
//   pkt_err       one-cycle pulse after a packet was cut at MAX_PKT beats
//
// Handshake: a beat transfers on any cycle where req_valid[i] && req_ready[i]
// are both high at the rising edge. Only the granted requester ever sees
// req_ready high; other requesters must hold valid/data/last stable.
module fifo_wr_sched #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int MAX_PKT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ready,
    output logic                      fifo_wr_en,
    output logic [WIDTH-1:0]          fifo_wr_data,
    input  logic                      fifo_full,
    input  logic [$clog2(DEPTH):0]    fifo_used,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic                      pkt_err
);

    localparam int IW = $clog2(NREQ);
    localparam int UW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(MAX_PKT + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_grant_id;
    logic [CW-1:0]   r_beat_cnt;
    logic            r_pkt_err;

    logic [UW-1:0]   w_free;
    logic            w_admit;
    logic            w_any_valid;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_winner;
    logic            w_g_valid;
    logic            w_g_last;
    logic [WIDTH-1:0] w_g_data;
    logic            w_accept;
    logic [CW-1:0]   w_cnt_next;

    // Occupancy is never above DEPTH, so the subtraction cannot wrap.
    assign w_free      = UW'(DEPTH) - fifo_used;
    assign w_admit     = (w_free >= UW'(MAX_PKT));
    assign w_any_valid = |req_valid;

    // Round-robin search starting just after the last winner. Scanning the
    // offsets from farthest to nearest lets the nearest valid index win.
    always_comb begin
        w_winner = '0;
        w_idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IW'((int'(r_rr_ptr) + k) % NREQ);
            if (req_valid[w_idx]) begin
                w_winner = w_idx;
            end
        end
    end

    // Select the granted requester's stream.
    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant_id == IW'(i)) begin
                w_g_valid = req_valid[i];
                w_g_last  = req_last[i];
                w_g_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == ST_LOCK) begin
            req_ready[r_grant_id] = !fifo_full;
        end
    end

    assign w_accept     = (r_state == ST_LOCK) && w_g_valid && !fifo_full;
    assign w_cnt_next   = r_beat_cnt + CW'(1);
    assign fifo_wr_en   = w_accept;
    assign fifo_wr_data = w_g_data;
    assign grant_id     = r_grant_id;
    assign busy         = (r_state == ST_LOCK);
    assign pkt_err      = r_pkt_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= IW'(NREQ - 1);
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_pkt_err  <= 1'b0;
        end else begin
            r_pkt_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid && w_admit) begin
                        r_grant_id <= w_winner;
                        r_rr_ptr   <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    // Grant is held indefinitely while the owner is idle.
                    if (w_accept) begin
                        r_beat_cnt <= w_cnt_next;
                        if (w_g_last) begin
                            r_state <= ST_IDLE;
                        end else if (w_cnt_next == CW'(MAX_PKT)) begin
                            // Oversized packet: close it here; the rest of
                            // the stream re-arbitrates as a new packet.
                            r_pkt_err <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Testbench for fifo_wr_sched: per-requester source queues drive the beats,
// and every expected FIFO write ({requester, data}) is pushed to exp_q when
// its beat is queued, then popped and compared when fifo_wr_en is observed.
module tb_fifo_wr_sched;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 16;
    localparam int MAX_PKT = 4;
    localparam int IW      = 2;
    localparam int UW      = 5;
    localparam int EW      = IW + WIDTH;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*WIDTH-1:0]  req_data = '0;
    logic [NREQ-1:0]        req_last = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   fifo_wr_en;
    logic [WIDTH-1:0]       fifo_wr_data;
    logic                   fifo_full = 1'b0;
    logic [UW-1:0]          fifo_used = '0;
    logic [IW-1:0]          grant_id;
    logic                   busy;
    logic                   pkt_err;

    int checks = 0;
    int failures = 0;

    logic [EW-1:0]    exp_q[$];
    logic [WIDTH:0]   src_q[NREQ][$];
    logic             last_wr;
    logic [NREQ-1:0]  last_ready;

    fifo_wr_sched #(
        .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_PKT(MAX_PKT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full), .fifo_used(fifo_used),
        .grant_id(grant_id), .busy(busy), .pkt_err(pkt_err)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Driver tasks
    task automatic drive_inputs();
        logic [WIDTH:0] b;
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                req_valid[i] = 1'b1;
                req_data[i*WIDTH +: WIDTH] = b[WIDTH-1:0];
                req_last[i] = b[WIDTH];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [IW-1:0] id, input logic [WIDTH-1:0] d, input logic last);
        src_q[id].push_back({last, d});
        exp_q.push_back({id, d});
    endtask

    // One clock: sample outputs at the falling edge (scoreboard pop and source
    // handshake), then advance past the rising edge and re-drive the sources.
    task automatic step();
        logic [EW-1:0]  e;
        logic [WIDTH:0] tmp;
        @(negedge clk);
        last_wr    = fifo_wr_en;
        last_ready = req_ready;
        if (fifo_wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_write got id=%0d data=%h expected no write", grant_id, fifo_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({grant_id, fifo_wr_data} !== e) begin
                    failures++;
                    $display("FAIL sb_write got id=%0d data=%h expected id=%0d data=%h",
                             grant_id, fifo_wr_data, e[EW-1:WIDTH], e[WIDTH-1:0]);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) tmp = src_q[i].pop_front();
        end
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_full = 1'b0;
        fifo_used = '0;
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        exp_q.delete();
        drive_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got %0d pending writes expected 0", name, exp_q.size());
        end
    endtask

    // Tests
    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, req_ready, fifo_wr_en, grant_id, pkt_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b ready=%b wr=%b gid=%0d err=%b expected all 0",
                     busy, req_ready, fifo_wr_en, grant_id, pkt_err);
        end
    endtask

    task automatic test_single();
        do_reset();
        send(0, 8'h11, 1'b0);
        send(0, 8'h22, 1'b0);
        send(0, 8'h33, 1'b1);
        drive_inputs();
        step();
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL single_grant got busy=%b gid=%0d expected busy=1 gid=0", busy, grant_id);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (last_wr !== 1'b1) begin
                failures++;
                $display("FAIL single_wr_beat%0d got wr=%b expected 1", k, last_wr);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got busy=%b expected 0", busy);
        end
        check_drained("single");
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NREQ; i++) send(IW'(i), 8'hA0 + 8'(i), 1'b1);
        for (int i = 0; i < NREQ; i++) send(IW'(i), 8'hB0 + 8'(i), 1'b1);
        // Writes leave the FIFO in order 0,1,2,3,0,1,2,3 (exp_q is already
        // in that order only if pushed per round; rebuild it accordingly).
        exp_q.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++)
                exp_q.push_back({IW'(i), (r == 0 ? 8'hA0 : 8'hB0) + 8'(i)});
        drive_inputs();
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if (last_wr !== 1'(k % 2)) begin
                failures++;
                $display("FAIL rr_spacing cycle%0d got wr=%b expected %0d", k, last_wr, k % 2);
            end
        end
        check_drained("rr");
    endtask

    task automatic test_admission();
        do_reset();
        fifo_used = 5'd13;
        send(1, 8'h55, 1'b1);
        drive_inputs();
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (busy !== 1'b0 || last_ready !== '0 || last_wr !== 1'b0) begin
                failures++;
                $display("FAIL adm_block cycle%0d got busy=%b ready=%b wr=%b expected 0 0 0",
                         k, busy, last_ready, last_wr);
            end
        end
        fifo_used = 5'd12;
        step();
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd1) begin
            failures++;
            $display("FAIL adm_grant got busy=%b gid=%0d expected busy=1 gid=1", busy, grant_id);
        end
        step();
        check_drained("adm");
        fifo_used = '0;
    endtask

    task automatic test_truncation();
        logic [7:0] exp_wr;
        logic [7:0] exp_busy;
        exp_wr   = 8'b1101_1110;  // bit k = write during step k
        exp_busy = 8'b1110_1111;  // bit k = busy after step k
        do_reset();
        for (int k = 0; k < 6; k++) send(2, 8'hC0 + 8'(k), 1'b0);
        drive_inputs();
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (last_wr !== exp_wr[k] || busy !== exp_busy[k] || pkt_err !== (k == 4)) begin
                failures++;
                $display("FAIL trunc cycle%0d got wr=%b busy=%b err=%b expected wr=%b busy=%b err=%b",
                         k, last_wr, busy, pkt_err, exp_wr[k], exp_busy[k], (k == 4));
            end
        end
        checks++;
        if (grant_id !== 2'd2) begin
            failures++;
            $display("FAIL trunc_regrant got gid=%0d expected 2", grant_id);
        end
        check_drained("trunc");
    endtask

    task automatic test_stall();
        do_reset();
        send(3, 8'hD0, 1'b0);
        send(3, 8'hD1, 1'b0);
        send(3, 8'hD2, 1'b0);
        send(3, 8'hD3, 1'b1);
        drive_inputs();
        step();
        step();
        fifo_full = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (last_ready !== '0 || last_wr !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cycle%0d got ready=%b wr=%b expected 0 0", k, last_ready, last_wr);
            end
        end
        fifo_full = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (last_ready !== 4'b1000 || last_wr !== 1'b1) begin
                failures++;
                $display("FAIL stall_resume cycle%0d got ready=%b wr=%b expected 1000 1", k, last_ready, last_wr);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_idle got busy=%b expected 0", busy);
        end
        check_drained("stall");
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        send(1, 8'hE0, 1'b0);
        send(1, 8'hE1, 1'b0);
        send(1, 8'hE2, 1'b0);
        send(1, 8'hE3, 1'b1);
        drive_inputs();
        step();
        step();
        step();
        checks++;
        if (exp_q.size() != 2) begin
            failures++;
            $display("FAIL rstmid_written got %0d pending expected 2", exp_q.size());
        end
        do_reset();
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_state got busy=%b gid=%0d expected busy=0 gid=0", busy, grant_id);
        end
        send(2, 8'hF2, 1'b1);
        send(0, 8'hF0, 1'b1);
        exp_q.delete();
        exp_q.push_back({2'd0, 8'hF0});
        exp_q.push_back({2'd2, 8'hF2});
        drive_inputs();
        step();
        checks++;
        if (last_wr !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_regrant got wr=%b busy=%b gid=%0d expected wr=0 busy=1 gid=0",
                     last_wr, busy, grant_id);
        end
        for (int k = 0; k < 3; k++) step();
        check_drained("rstmid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_admission();
        test_truncation();
        test_stall();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_sched.md
Name: fifo_wr_sched

Overview:
- Packet-level round-robin write scheduler in front of the shared `fifo` block.
- Arbitrates NREQ requester streams into the single FIFO write port.
- Holds the grant for a whole packet so packets never interleave.
- Admits a packet only when the FIFO has room for a maximum-size packet.

Parameters:
- NREQ, 4, number of requesters (>=2).
- WIDTH, 8, data width; matches FIFO WIDTH.
- DEPTH, 16, FIFO depth; matches FIFO DEPTH.
- MAX_PKT, 4, maximum beats per packet and admission threshold (1..DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_data  in  NREQ*WIDTH  per-requester beat; requester i occupies [i*WIDTH +: WIDTH].
- req_last  in  NREQ  final beat of the packet.
- req_ready  out  NREQ  beat accepted when valid&&ready.
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_wr_data  out  WIDTH  to FIFO wr_data.
- fifo_full  in  1  from FIFO full.
- fifo_used  in  $clog2(DEPTH)+1  from FIFO used.
- grant_id  out  $clog2(NREQ)  currently/last granted requester.
- busy  out  1  high in LOCK state.
- pkt_err  out  1  one-cycle pulse on packet truncation.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, rr_ptr=NREQ-1, beat_cnt=0, grant_id=0, pkt_err=0. All outputs derived from state are 0: req_ready=0, fifo_wr_en=0, busy=0.
- Free slots: free = DEPTH - fifo_used (full width, no wrap).
- Admission condition: free >= MAX_PKT.
- IDLE state:
  - req_ready=0, fifo_wr_en=0.
  - If any req_valid and the admission condition holds: winner = first valid index searching rr_ptr+1, rr_ptr+2, … modulo NREQ.
  - At that posedge: grant_id<=winner, rr_ptr<=winner, beat_cnt<=0, state<=LOCK.
  - Otherwise stay in IDLE; no grant is issued while free < MAX_PKT.
- LOCK state (g=grant_id):
  - busy=1.
  - req_ready[g] = !fifo_full; all other req_ready bits are 0.
  - accept = req_valid[g] && req_ready[g].
  - fifo_wr_en = accept (combinational, same cycle).
  - fifo_wr_data = req_data[g] slice.
  - On accept, beat_cnt increments.
  - If req_last[g] is set on the accepted beat: state<=IDLE.
  - Else if beat_cnt+1 == MAX_PKT: the beat is treated as last; pkt_err pulses 1 cycle later for exactly 1 cycle; state<=IDLE. Following beats from that requester form a new packet and must re-arbitrate.
  - Valid deasserting mid-packet: the grant is held, with no timeout.
- Latency:
  - Grant takes 1 cycle from IDLE; the first beat can be written in the first LOCK cycle.
  - One IDLE bubble cycle separates packets, including back-to-back packets from the same requester.
- Fairness: the last winner gets lowest priority next round, so any continuously valid requester is granted within NREQ packets.
- Admission guarantees fifo_full is never seen in LOCK when DEPTH >= MAX_PKT and the FIFO is not otherwise written. req_ready still gates on fifo_full as defence.
- Concurrent FIFO reads do not affect an in-progress packet; admission uses fifo_used only in IDLE.
- Reset asserted in LOCK: abandons the packet at that edge. Beats already written remain in the FIFO; FIFO flush is the system's responsibility. No write occurs in the reset cycle's successor.
- Non-granted requesters' valid/data/last are ignored and must be held by their sources.

Test Plan:
- Single packet: req0 sends 3 beats 0x11,0x22,0x33 (last on 0x33), fifo_used=0 → grant_id=0 after 1 cycle; fifo_wr_en high 3 consecutive cycles with data 0x11,0x22,0x33; return to IDLE; busy low.
- Round-robin: req0..req3 all continuously valid with 1-beat packets, post-reset → grant order 0,1,2,3,0; each write is separated by 1 IDLE cycle.
- Admission: fifo_used=13 (free=3 < MAX_PKT=4) with req1 valid → no grant and req_ready=0; drop fifo_used to 12 → grant_id=1 next cycle.
- Truncation: req2 sends 6 beats without last → first 4 beats written; pkt_err pulses once; IDLE bubble; remaining 2 beats re-arbitrated as a new packet.
- Stall: in LOCK, force fifo_full=1 for 2 cycles mid-packet → req_ready[g]=0 and fifo_wr_en=0 for those cycles; no beat is lost or duplicated afterwards.
- Reset mid-packet: assert rst after beat 2 of 4 → next cycle IDLE, busy=0, grant_id=0; the next arbitration starts from requester 0.
